// File: rtl/comp_layer.sv
// Sequential arg-max over twelve packed signed element pairs: q = index of max(d1_i + d2_i), lowest index on ties.
// Optional macro COMP_LATCH_INPUTS_EN captures d1/d2 at load; otherwise d1/d2 are read live during RUN.
module comp_layer #(
  parameter int DATA_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [12*DATA_LEN-1:0]   d1,
  input  logic [12*DATA_LEN-1:0]   d2,
  output logic                     valid,
  output logic [3:0]               q,
  output logic [1:0]               fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic signed [DATA_LEN:0] SCORE_MIN = {1'b1, {DATA_LEN{1'b0}}};

  state_t                    state, state_nx;
  logic [3:0]                idx, idx_nx;
  logic [3:0]                best_idx, best_idx_nx;
  logic [3:0]                q_nx;
  logic signed [DATA_LEN:0]  best, best_nx;
  logic signed [DATA_LEN:0]  score;
  logic [DATA_LEN-1:0]       e1, e2;
  logic                      better;
  logic [12*DATA_LEN-1:0]    src1, src2;

`ifdef COMP_LATCH_INPUTS_EN
  logic [12*DATA_LEN-1:0] d1_r, d2_r;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      d1_r <= '0;
      d2_r <= '0;
    end else if (state == IDLE && load) begin
      d1_r <= d1;
      d2_r <= d2;
    end
  end

  assign src1 = d1_r;
  assign src2 = d2_r;
`else
  assign src1 = d1;
  assign src2 = d2;
`endif

  // Element mux for the current index; idx never exceeds 11 while RUN is active.
  always_comb begin
    e1 = '0;
    e2 = '0;
    for (int i = 0; i < 12; i++) begin
      if (idx == 4'(i)) begin
        e1 = src1[i*DATA_LEN +: DATA_LEN];
        e2 = src2[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  assign score  = $signed({e1[DATA_LEN-1], e1}) + $signed({e2[DATA_LEN-1], e2});
  assign better = (score > best);

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    best_nx     = best;
    best_idx_nx = best_idx;
    q_nx        = q;
    case (state)
      IDLE: begin
        if (load) begin
          state_nx    = RUN;
          idx_nx      = 4'd0;
          best_nx     = SCORE_MIN;
          best_idx_nx = 4'd0;
        end
      end
      RUN: begin
        if (better) begin
          best_nx     = score;
          best_idx_nx = idx;
        end
        if (idx == 4'd11) begin
          // Last element folds straight into q so DONE carries the final answer.
          state_nx = DONE;
          idx_nx   = 4'd0;
          q_nx     = better ? idx : best_idx;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      idx      <= 4'd0;
      best     <= '0;
      best_idx <= 4'd0;
      q        <= 4'd0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      best     <= best_nx;
      best_idx <= best_idx_nx;
      q        <= q_nx;
    end
  end

  assign valid     = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_comp_layer.sv
// Directed bench for comp_layer: stimulus pushes expected q and valid cycle; a monitor pops on each valid.
module tb_comp_layer;

  localparam int W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              load = 1'b0;
  logic [12*W-1:0]   d1 = '0;
  logic [12*W-1:0]   d2 = '0;
  logic              valid;
  logic [3:0]        q;
  logic [1:0]        fsm_state;

  int                a1 [12];
  int                a2 [12];
  logic [3:0]        exp_q [$];
  int                exp_t [$];
  logic [3:0]        prev_q = 4'd0;
  int                cyc = 0;
  int                checks = 0;
  int                failures = 0;

  comp_layer #(.DATA_LEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .d1        (d1),
    .d2        (d2),
    .valid     (valid),
    .q         (q),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid must match the head of the expected queue, in value and cycle.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid=1 q=%0d at cycle %0d, required no valid", q, cyc);
      end else begin
        logic [3:0] eq;
        int         et;
        eq = exp_q.pop_front();
        et = exp_t.pop_front();
        checks++;
        if (q !== eq) begin
          failures++;
          $display("FAIL result_q: got %0d, required %0d", q, eq);
        end
        checks++;
        if (cyc != et) begin
          failures++;
          $display("FAIL latency: valid at cycle %0d, required cycle %0d", cyc, et);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic clear_vec();
    for (int i = 0; i < 12; i++) begin
      a1[i] = 0;
      a2[i] = 0;
    end
  endtask

  task automatic pack();
    for (int i = 0; i < 12; i++) begin
      d1[i*W +: W] = W'(a1[i]);
      d2[i*W +: W] = W'(a2[i]);
    end
  endtask

  // One full run; optional scramble alters the inputs right after the load edge.
  task automatic run_vec(input logic [3:0] exp, input bit scramble);
    pack();
    exp_q.push_back(exp);
    exp_t.push_back(cyc + 13);
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    if (scramble) begin
      d1 = '0;
      d2 = '0;
      d1[9*W +: W] = 16'd500;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("q_hold_in_run", q, prev_q);
    prev_q = exp;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_q", q, 0);
    check("reset_state", fsm_state, 0);
    @(posedge clk);
    #1;

    clear_vec(); a1[5] = 100;
    run_vec(4'd5, 1'b0);

    clear_vec();
    for (int i = 0; i < 12; i++) begin a1[i] = -3; a2[i] = -3; end
    run_vec(4'd0, 1'b0);
    a1[11] = 32767; a2[11] = 32767;
    run_vec(4'd11, 1'b0);

    for (int i = 0; i < 12; i++) begin a1[i] = i; a2[i] = -2 * i; end
    run_vec(4'd0, 1'b0);
    for (int i = 0; i < 12; i++) begin a1[i] = -i; a2[i] = 2 * i; end
    run_vec(4'd11, 1'b0);

    for (int i = 0; i < 12; i++) begin a1[i] = -32768; a2[i] = -32768; end
    run_vec(4'd0, 1'b0);

    clear_vec(); a1[3] = 50; a1[7] = 20; a2[7] = 30;
    run_vec(4'd3, 1'b0);

    // Extra load pulses at run cycles 3, 12 and through DONE must be ignored.
    clear_vec(); a1[7] = 9;
    pack();
    exp_q.push_back(4'd7);
    exp_t.push_back(cyc + 13);
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (2) @(posedge clk);
    #1 load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (8) @(posedge clk);
    #1 load = 1'b1;
    repeat (2) @(posedge clk);
    #1 load = 1'b0;
    prev_q = 4'd7;
    repeat (20) @(posedge clk);
    #1;

    // Reset in RUN cycle 6 aborts the run; q clears and no valid appears.
    clear_vec(); a1[2] = 1; a2[2] = 1;
    pack();
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    load = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    load = 1'b0;
    @(negedge clk);
    check("abort_q", q, 0);
    check("abort_state", fsm_state, 0);
    prev_q = 4'd0;
    repeat (16) @(posedge clk);
    #1;
    run_vec(4'd2, 1'b0);

    clear_vec(); a1[5] = 100;
`ifdef COMP_LATCH_INPUTS_EN
    run_vec(4'd5, 1'b1);
`else
    run_vec(4'd5, 1'b0);
`endif

    for (int k = 0; k < 40 && exp_q.size() > 0; k++) @(posedge clk);
    check("pending_results", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comp_layer.md
COMP_LAYER -- requirements
Module: comp_layer

Interface
REQ-001 The module SHALL have parameter DATA_LEN, default 16, giving the width of one signed two's-complement element.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: synchronous, active-high reset; the name is kept for codebase consistency.
REQ-004 The module SHALL have port load, input, 1 bit: starts one comparison when sampled high in IDLE.
REQ-005 The module SHALL have port d1, input, 12*DATA_LEN bits: element i at bits [i*DATA_LEN +: DATA_LEN], i = 0..11.
REQ-006 The module SHALL have port d2, input, 12*DATA_LEN bits, packed the same way as d1.
REQ-007 The module SHALL have port valid, output, 1 bit: one-cycle pulse marking a new result on q.
REQ-008 The module SHALL have port q, output, 4 bits: winning element index, range 0..11.

Function
REQ-009 The module SHALL define score_i = d1_i + d2_i, sign-extended to DATA_LEN+1 bits with no overflow or saturation.
REQ-010 q SHALL be the index i with the maximum score_i; on equal scores, the lowest index wins (strict greater-than replaces the best).
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 In IDLE with load=1, the next state SHALL be RUN with index counter = 0 and best score = most-negative value.
REQ-013 Each RUN cycle SHALL evaluate element idx, update best index/score if score_idx > best, and increment idx.
REQ-014 After evaluating idx = 11, the FSM SHALL go to DONE and register the best index into q.
REQ-015 DONE SHALL last one cycle with valid = 1, then return to IDLE; valid SHALL be 0 in every other state.
REQ-016 Latency SHALL be fixed: load sampled at edge T gives valid high in the cycle after edge T+12, for exactly one cycle.
REQ-017 load SHALL be ignored in RUN and DONE; a load held high through DONE starts a new run only from IDLE.
REQ-018 q SHALL hold its last result until the next DONE and SHALL NOT change during RUN.

Reset
REQ-019 rst_n = 1 at a rising edge SHALL force state IDLE, idx 0, best score/index cleared, valid 0 and q 0.
REQ-020 Reset during RUN or DONE SHALL abort the run with no valid pulse; reset SHALL take priority over load.

Configuration
REQ-021 The block SHALL support macro COMP_LATCH_INPUTS_EN.
REQ-022 With COMP_LATCH_INPUTS_EN defined, d1/d2 SHALL be captured into internal registers on the accepting load edge, and RUN SHALL use only the captured copy.
REQ-023 Without COMP_LATCH_INPUTS_EN, RUN SHALL read d1/d2 live each cycle, and the driver SHALL hold the inputs stable from load until valid.

Verification (DATA_LEN = 16)
REQ-024 Scenario: d1_5 = 100, all other d1 = 0, all d2 = 0, load pulse -> valid exactly 13 cycles later for one cycle, q = 5.
REQ-025 Scenario: all d1 and d2 = -3 (ties) -> q = 0; then d1_11 = 0x7FFF and d2_11 = 0x7FFF (no overflow, score 65534) -> q = 11.
REQ-026 Scenario: d1_i = i, d2_i = -2*i -> q = 0; then d1_i = -i, d2_i = 2*i -> q = 11.
REQ-027 Scenario: load pulsed again at cycles 3 and 12 of a run -> single valid at cycle 13, and no second run starts.
REQ-028 Scenario: rst_n asserted at RUN cycle 6 -> valid never pulses, q = 0; a fresh load then gives a correct result 13 cycles later.
REQ-029 Scenario, macro defined: inputs changed one cycle after load -> q reflects the values at load; macro undefined: held inputs give the same q as the first scenario.
